sram_controller: RTL
====================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter SRAM_WAIT, default 2: clock cycles spent on each 16-bit half access (min 1).
REQ-002 Parameter DATA_BASE, default 1024: byte address mapped to SRAM word 0.
REQ-003 clk  in  1  sole clock; all state changes on posedge clk.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 rd_en  in  1  MEM-stage load request, from EXE-stage register mem_read_out.
REQ-006 wr_en  in  1  MEM-stage store request, from EXE-stage register mem_write_out.
REQ-007 address  in  `REGISTER_LEN (32)  byte address, from EXE-stage register alu_res_out.
REQ-008 write_data  in  `REGISTER_LEN (32)  store data, from EXE-stage register val_rm_out.
REQ-009 read_data  out  32  load result; valid while ready=1 in DONE.
REQ-010 ready  out  1  combinational; ~ready drives the pipeline freeze of all stage registers.
REQ-011 SRAM_DQ  inout  16  external data bus; driven only in write states, else high-Z.
REQ-012 SRAM_ADDR  out  18  external half-word address.
REQ-013 SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low strobes.

Function
REQ-014 States: IDLE, LO, HI, DONE; 3-bit wait counter wcnt.
REQ-015 ready = 1 when (rd_en|wr_en)=0 or state=DONE; else 0, including the request cycle in IDLE.
REQ-016 IDLE with rd_en|wr_en=1 -> LO, wcnt=0; otherwise stay IDLE.
REQ-017 LO: wcnt increments each cycle; on wcnt=SRAM_WAIT-1 -> HI, wcnt=0.
REQ-018 HI: same count rule; on wcnt=SRAM_WAIT-1 -> DONE.
REQ-019 DONE -> IDLE unconditionally, so a held request is not re-issued; pipeline advances on the DONE edge.
REQ-020 Word index w = ((address - DATA_BASE) >> 2) mod 2^17; SRAM_ADDR = {w,1'b0} in LO, {w,1'b1} in HI, 0 elsewhere.
REQ-021 Addresses below DATA_BASE wrap modulo 2^17 words; no error flag.
REQ-022 Write: SRAM_WE_N=0 in LO/HI; SRAM_DQ = write_data[15:0] in LO, write_data[31:16] in HI.
REQ-023 Read: SRAM_OE_N=0 in LO/HI; SRAM_DQ sampled into read_data[15:0] on last LO cycle and read_data[31:16] on last HI cycle.
REQ-024 read_data holds its value until the next read capture; writes leave it unchanged.
REQ-025 rd_en and wr_en both 1: treated as write.
REQ-026 SRAM_CE_N, SRAM_UB_N, SRAM_LB_N tied 0; SRAM_WE_N, SRAM_OE_N = 1 outside LO/HI.
REQ-027 Request fields are used live from the frozen EXE-stage register; no internal capture of address/write_data.
REQ-028 Access latency: ready rises 2*SRAM_WAIT+1 cycles after the request cycle (6 cycles total for default).

Reset
REQ-029 rst=1 at posedge: state=IDLE, wcnt=0, read_data=0; takes priority over every transition.
REQ-030 Reset mid-access aborts it: next cycle WE_N=1, OE_N=1, SRAM_DQ high-Z, SRAM_ADDR=0; a partial write is not completed.

Structure
REQ-031 defines.v gains `SRAM_ADDR_LEN (18) and `SRAM_DATA_LEN (16); existing `REGISTER_LEN reused.
REQ-032 State encodings are local parameters in this module, not in defines.v.
REQ-033 No RTL sub-module; the bench uses a behavioural sram_model (256K x 16, async read) on SRAM_*.

Verification
REQ-034 Write 0xDEADBEEF to 1028 -> SRAM[2]=0xBEEF, SRAM[3]=0xDEAD; ready=0 for 5 cycles, 1 on cycle 6.
REQ-035 Read 1028 after REQ-034 -> read_data=0xDEADBEEF with ready=1 in DONE; then IDLE.
REQ-036 Back-to-back load then store with no gap -> two complete 6-cycle accesses; no skipped or doubled access.
REQ-037 rst asserted during HI of a write to 1032 -> SRAM[5] unchanged, WE_N=1 and DQ high-Z next cycle, state IDLE.
REQ-038 rd_en=wr_en=1, address 1024, data 0x12345678 -> write performed, read_data unchanged.
REQ-039 Write to 1020 -> wraps to w=0x1FFFF, SRAM_ADDR 0x3FFFE/0x3FFFF.

Source files
------------

// File: rtl/sram_controller_pkg.sv
// Shared widths and helpers for the 16-bit external SRAM controller.
package sram_controller_pkg;

    localparam int unsigned REGISTER_LEN  = 32;
    localparam int unsigned SRAM_ADDR_LEN = 18;
    localparam int unsigned SRAM_DATA_LEN = 16;
    localparam int unsigned WORD_IDX_LEN  = SRAM_ADDR_LEN - 1;

    // A 32-bit word occupies two consecutive half-word locations.
    function automatic logic [SRAM_ADDR_LEN-1:0] half_addr(input logic [WORD_IDX_LEN-1:0] word_idx,
                                                           input logic                    upper);
        return {word_idx, upper};
    endfunction

endpackage

// File: rtl/sram_controller.sv
// MEM-stage controller: splits a 32-bit load/store into two 16-bit SRAM accesses
// and holds the pipeline (ready=0) until the access completes.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned SRAM_WAIT = 2,
    parameter int unsigned DATA_BASE = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic                     wr_en,
    input  logic [REGISTER_LEN-1:0]  address,
    input  logic [REGISTER_LEN-1:0]  write_data,
    output logic [REGISTER_LEN-1:0]  read_data,
    output logic                     ready,
    inout  wire  [SRAM_DATA_LEN-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_LEN-1:0] SRAM_ADDR,
    output logic                     SRAM_WE_N,
    output logic                     SRAM_OE_N,
    output logic                     SRAM_CE_N,
    output logic                     SRAM_UB_N,
    output logic                     SRAM_LB_N
);

    typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_t;

    localparam logic [2:0] LAST = 3'(SRAM_WAIT - 1);

    state_t                  state;
    logic [2:0]              wcnt;
    logic                    req;
    logic                    is_write;
    logic                    active;
    logic [REGISTER_LEN-1:0] offset;
    logic [WORD_IDX_LEN-1:0] word_idx;
    logic                    unused_offset;

    assign req      = rd_en | wr_en;
    // A simultaneous read and write request is serviced as a write.
    assign is_write = wr_en;
    assign active   = (state == StLo) || (state == StHi);

    // Addresses below DATA_BASE wrap around the 2^17-word space.
    assign offset        = address - REGISTER_LEN'(DATA_BASE);
    assign word_idx      = offset[18:2];
    assign unused_offset = ^{offset[REGISTER_LEN-1:19], offset[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            wcnt      <= '0;
            read_data <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (req) begin
                        state <= StLo;
                        wcnt  <= '0;
                    end
                end
                StLo: begin
                    if (wcnt == LAST) begin
                        state <= StHi;
                        wcnt  <= '0;
                        if (!is_write) read_data[15:0] <= SRAM_DQ;
                    end else begin
                        wcnt <= wcnt + 3'd1;
                    end
                end
                StHi: begin
                    if (wcnt == LAST) begin
                        state <= StDone;
                        wcnt  <= '0;
                        if (!is_write) read_data[31:16] <= SRAM_DQ;
                    end else begin
                        wcnt <= wcnt + 3'd1;
                    end
                end
                // Always drop back to idle so a request still held here is not re-issued.
                StDone:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    always_comb begin
        SRAM_ADDR = '0;
        if (state == StLo) SRAM_ADDR = half_addr(word_idx, 1'b0);
        if (state == StHi) SRAM_ADDR = half_addr(word_idx, 1'b1);
    end

    assign ready     = !req || (state == StDone);
    assign SRAM_WE_N = !(active && is_write);
    assign SRAM_OE_N = !(active && !is_write);
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    assign SRAM_DQ = (active && is_write) ?
                     ((state == StHi) ? write_data[31:16] : write_data[15:0]) : 16'hzzzz;

endmodule
